exec_ctrl: RTL and testbench

EXEC_CTRL -- requirements
Module: exec_ctrl

---
 rtl/exec_ctrl_pkg.sv | 23 ++
 rtl/exec_ctrl_wait_cnt.sv | 25 ++
 rtl/exec_ctrl.sv | 131 +++++++++++++
 tb/tb_exec_ctrl.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the execute controller: FSM encoding, instruction
// field positions and the NOP opcode.
package exec_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } state_t;

   localparam int OP_LSB = 12;
   localparam int RW_LSB = 8;
   localparam int RA_LSB = 4;
   localparam int RB_LSB = 0;

   localparam logic [3:0] OP_NOP = 4'hF;

   function automatic logic [3:0] instr_field(input logic [15:0] i_instr, input int i_lsb);
      return i_instr[i_lsb +: 4];
   endfunction

endpackage

// File: rtl/exec_ctrl_wait_cnt.sv
// 4-bit loadable down-counter; o_term flags the last cycle of a wait period.
module wait_cnt (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_load,
   input  logic [3:0] i_load_val,
   input  logic       i_dec,
   output logic       o_term
);

   logic [3:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= 4'd0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != 4'd0)) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   assign o_term = (r_cnt == 4'd1);

endmodule

// File: rtl/exec_ctrl.sv
// Single-issue execute controller: fetches operands from the register file,
// drives the ALU, writes the result back and counts retired instructions.
module exec_ctrl
   import exec_ctrl_pkg::*;
#(
   parameter int RD_WAIT = 1,
   parameter int EX_WAIT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [15:0] instr,
   output logic [3:0]  rf_ra,
   output logic [3:0]  rf_rb,
   input  logic [15:0] rf_adat,
   input  logic [15:0] rf_bdat,
   output logic [3:0]  rf_rw,
   output logic        rf_wren,
   output logic [15:0] rf_wdat,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [3:0]  alu_op,
   input  logic [15:0] alu_result,
   output logic        done,
   output logic [15:0] retired_cnt
);

   localparam logic [3:0] RD_LOAD = 4'(RD_WAIT);
   localparam logic [3:0] EX_LOAD = 4'(EX_WAIT);

   state_t      r_state;
   logic [15:0] r_instr;
   logic        r_instr_ready;
   logic [3:0]  r_rf_rw;
   logic        r_rf_wren;
   logic [15:0] r_result;
   logic [15:0] r_alu_a;
   logic [15:0] r_alu_b;
   logic [3:0]  r_alu_op;
   logic        r_done;
   logic [15:0] r_retired_cnt;

   logic        w_accept;
   logic        w_term;
   logic        w_load;
   logic [3:0]  w_load_val;
   logic        w_dec;
   logic [3:0]  w_op;

   assign w_accept   = instr_valid && r_instr_ready;
   assign w_op       = instr_field(r_instr, OP_LSB);
   // One counter times both phases: loaded on accept for READ, on READ exit for EXEC.
   assign w_load     = ((r_state == ST_IDLE) && w_accept) || ((r_state == ST_READ) && w_term);
   assign w_load_val = (r_state == ST_IDLE) ? RD_LOAD : EX_LOAD;
   assign w_dec      = (r_state == ST_READ) || (r_state == ST_EXEC);

   wait_cnt u_wait_cnt (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_dec      (w_dec),
      .o_term     (w_term)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_instr       <= 16'd0;
         r_instr_ready <= 1'b1;
         r_rf_rw       <= 4'd0;
         r_rf_wren     <= 1'b0;
         r_result      <= 16'd0;
         r_alu_a       <= 16'd0;
         r_alu_b       <= 16'd0;
         r_alu_op      <= 4'd0;
         r_done        <= 1'b0;
         r_retired_cnt <= 16'd0;
      end else begin
         r_done    <= 1'b0;
         r_rf_wren <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_instr       <= instr;
                  r_instr_ready <= 1'b0;
                  r_state       <= ST_READ;
               end
            end
            ST_READ: begin
               if (w_term) begin
                  r_alu_a  <= rf_adat;
                  r_alu_b  <= rf_bdat;
                  r_alu_op <= w_op;
                  r_state  <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               // Write strobe and done are registered here so they line up with WB.
               if (w_term) begin
                  r_result      <= alu_result;
                  r_rf_rw       <= instr_field(r_instr, RW_LSB);
                  r_rf_wren     <= (w_op != OP_NOP);
                  r_done        <= 1'b1;
                  r_retired_cnt <= r_retired_cnt + 16'd1;
                  r_state       <= ST_WB;
               end
            end
            ST_WB: begin
               r_instr_ready <= 1'b1;
               r_state       <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign instr_ready = r_instr_ready;
   assign rf_ra       = instr_field(r_instr, RA_LSB);
   assign rf_rb       = instr_field(r_instr, RB_LSB);
   assign rf_rw       = r_rf_rw;
   assign rf_wren     = r_rf_wren;
   assign rf_wdat     = r_result;
   assign alu_a       = r_alu_a;
   assign alu_b       = r_alu_b;
   assign alu_op      = r_alu_op;
   assign done        = r_done;
   assign retired_cnt = r_retired_cnt;

endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: a register file and ALU environment, a reference model
// of the instruction stream, and directed plus randomized scenarios.
module tb_exec_ctrl;

   localparam int RD  = 1;
   localparam int EX  = 2;
   localparam int LAT = RD + EX + 1;
   localparam int GAP = RD + EX + 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [15:0] instr = 16'd0;
   logic [3:0]  rf_ra, rf_rb, rf_rw, alu_op;
   logic [15:0] rf_adat, rf_bdat, rf_wdat, alu_a, alu_b, alu_result, retired_cnt;
   logic        rf_wren, done;

   logic        instr2_valid = 1'b0;
   logic        instr2_ready;
   logic [15:0] instr2 = 16'd0;
   logic [3:0]  rf2_ra, rf2_rb, rf2_rw, alu2_op;
   logic [15:0] rf2_adat = 16'd0;
   logic [15:0] rf2_bdat, rf2_wdat, alu2_a, alu2_b, alu2_result, retired2_cnt;
   logic        rf2_wren, done2;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   logic [15:0] rf_mem [16];
   logic [15:0] model_rf [16];
   logic [15:0] model_ret = 16'd0;
   logic [52:0] exp_q [$];
   logic        preload = 1'b0;

   function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op[1:0])
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a + b;
         default: return a - b;
      endcase
   endfunction

   assign rf_adat     = rf_mem[rf_ra];
   assign rf_bdat     = rf_mem[rf_rb];
   assign alu_result  = alu_fn(alu_op, alu_a, alu_b);
   assign rf2_bdat    = 16'h00AA;
   assign alu2_result = alu2_a + alu2_b;

   exec_ctrl dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_adat(rf_adat), .rf_bdat(rf_bdat), .rf_rw(rf_rw),
      .rf_wren(rf_wren), .rf_wdat(rf_wdat), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .done(done), .retired_cnt(retired_cnt)
   );

   exec_ctrl #(.RD_WAIT(3), .EX_WAIT(1)) dut2 (
      .clk(clk), .rst(rst), .instr_valid(instr2_valid), .instr_ready(instr2_ready), .instr(instr2),
      .rf_ra(rf2_ra), .rf_rb(rf2_rb), .rf_adat(rf2_adat), .rf_bdat(rf2_bdat), .rf_rw(rf2_rw),
      .rf_wren(rf2_wren), .rf_wdat(rf2_wdat), .alu_a(alu2_a), .alu_b(alu2_b), .alu_op(alu2_op),
      .alu_result(alu2_result), .done(done2), .retired_cnt(retired2_cnt)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: expected write per accepted instruction, from the model register file.
   always @(negedge clk) begin
      logic [52:0] e;
      logic [3:0]  op;
      logic [15:0] res;
      if (rst) begin
         exp_q.delete();
         model_ret = 16'd0;
         for (int i = 0; i < 16; i++) rf_mem[i] = 16'($urandom);
         rf_mem[1] = 16'h0005;
         rf_mem[2] = 16'h0007;
         model_rf = rf_mem;
      end else begin
         if (preload) model_ret = 16'hFFFF;
         if (instr_valid && instr_ready) begin
            op  = instr[15:12];
            res = alu_fn(op, model_rf[instr[7:4]], model_rf[instr[3:0]]);
            exp_q.push_back({op != 4'hF, instr[11:8], res, cyc});
         end
         if (done) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected_done got done=1 want no retire pending");
            end else begin
               e = exp_q.pop_front();
               checks++;
               if (rf_wren !== e[52]) begin
                  errors++;
                  $display("FAIL sb_wren got %0b want %0b", rf_wren, e[52]);
               end
               checks++;
               if ((cyc - e[31:0]) != LAT) begin
                  errors++;
                  $display("FAIL sb_latency got %0d want %0d", cyc - e[31:0], LAT);
               end
               if (e[52]) begin
                  checks++;
                  if (rf_rw !== e[51:48] || rf_wdat !== e[47:32]) begin
                     errors++;
                     $display("FAIL sb_write got rw=%0h wdat=%h want rw=%0h wdat=%h", rf_rw, rf_wdat, e[51:48], e[47:32]);
                  end
                  model_rf[e[51:48]] = e[47:32];
               end
               model_ret = model_ret + 16'd1;
            end
         end else if (rf_wren) begin
            checks++;
            errors++;
            $display("FAIL sb_stray_wren got rf_wren=1 want 0 outside retire");
         end
         if (instr_ready) begin
            checks++;
            if (retired_cnt !== model_ret) begin
               errors++;
               $display("FAIL sb_retired got %h want %h", retired_cnt, model_ret);
            end
         end
         if (rf_wren) rf_mem[rf_rw] = rf_wdat;
      end
   end

   task automatic send(input logic [15:0] v, output int unsigned acc);
      int i;
      @(posedge clk); #1;
      instr = v;
      instr_valid = 1'b1;
      for (i = 0; i < 100; i++) begin
         @(negedge clk);
         if (instr_ready) break;
      end
      acc = cyc;
      checks++;
      if (i == 100) begin
         errors++;
         $display("FAIL send_timeout got no instr_ready want accept within 100 cycles");
      end
      @(posedge clk); #1;
      instr_valid = 1'b0;
   endtask

   task automatic wait_done();
      int i;
      for (i = 0; i < 50; i++) begin
         @(negedge clk);
         if (done) break;
      end
      checks++;
      if (i == 50) begin
         errors++;
         $display("FAIL done_timeout got no done want done within 50 cycles");
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      int unsigned acc;
      int          i;
      int          wren_n;
      repeat (3) @(negedge clk);
      checks++;
      if (rf_wren !== 1'b0 || done !== 1'b0 || retired_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_ctrl got wren=%0b done=%0b ret=%h want 0 0 0000", rf_wren, done, retired_cnt);
      end
      checks++;
      if ({rf_ra, rf_rb, rf_rw, alu_op, rf_wdat, alu_a, alu_b} !== 64'd0) begin
         errors++;
         $display("FAIL reset_data got %h want 0", {rf_ra, rf_rb, rf_rw, alu_op, rf_wdat, alu_a, alu_b});
      end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (instr_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got %0b want 1", instr_ready);
      end
      send(16'h0123, acc);
      wait_done();
      // Abort an instruction in EXEC.
      send(16'h3456, acc);
      @(posedge clk); #2 rst = 1'b1;
      #1;
      checks++;
      if (rf_wren !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_exec_wren got wren=%0b done=%0b want 0 0", rf_wren, done);
      end
      @(negedge clk);
      @(posedge clk); #1 rst = 1'b0;
      wren_n = 0;
      for (i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rf_wren) wren_n++;
      end
      checks++;
      if (wren_n != 0 || instr_ready !== 1'b1 || retired_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_exec_after got wren_n=%0d ready=%0b ret=%h want 0 1 0000", wren_n, instr_ready, retired_cnt);
      end
      // Abort while the write strobe is up: it must drop without a clock edge.
      send(16'h2111, acc);
      for (i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rf_wren) break;
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if (i == 20 || rf_wren !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_wb_async got wait=%0d wren=%0b done=%0b want wb seen, 0 0", i, rf_wren, done);
      end
      @(negedge clk);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (retired_cnt !== 16'd0 || instr_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_wb_after got ret=%h ready=%0b want 0000 1", retired_cnt, instr_ready);
      end
   endtask

   task automatic test_basic();
      int unsigned acc;
      int          i;
      send(16'h2312, acc);
      for (i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rf_wren) break;
      end
      checks++;
      if (i == 20 || (cyc - acc) != 4) begin
         errors++;
         $display("FAIL basic_latency got %0d want 4", cyc - acc);
      end
      checks++;
      if (rf_rw !== 4'd3 || rf_wdat !== 16'h000C || done !== 1'b1) begin
         errors++;
         $display("FAIL basic_write got rw=%0h wdat=%h done=%0b want 3 000c 1", rf_rw, rf_wdat, done);
      end
      @(negedge clk);
      checks++;
      if (rf_wren !== 1'b0 || done !== 1'b0 || retired_cnt !== 16'd1) begin
         errors++;
         $display("FAIL basic_after got wren=%0b done=%0b ret=%h want 0 0 0001", rf_wren, done, retired_cnt);
      end
   endtask

   task automatic test_nop();
      int unsigned acc;
      int          wren_n;
      int          done_n;
      wren_n = 0;
      done_n = 0;
      send(16'hF123, acc);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (rf_wren) wren_n++;
         if (done) done_n++;
      end
      checks++;
      if (wren_n != 0 || done_n != 1 || retired_cnt !== 16'd2) begin
         errors++;
         $display("FAIL nop got wren_n=%0d done_n=%0d ret=%h want 0 1 0002", wren_n, done_n, retired_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] b2b [3];
      int unsigned acc [3];
      int          n;
      b2b[0] = 16'h2442;
      b2b[1] = 16'h0567;
      b2b[2] = 16'h3778;
      n = 0;
      @(posedge clk); #1;
      instr = b2b[0];
      instr_valid = 1'b1;
      for (int i = 0; i < 40 && n < 3; i++) begin
         @(negedge clk);
         if (instr_ready) begin
            acc[n] = cyc;
            n++;
            @(posedge clk); #1;
            if (n < 3) instr = b2b[n];
            else instr_valid = 1'b0;
         end
      end
      instr_valid = 1'b0;
      checks++;
      if (n != 3) begin
         errors++;
         $display("FAIL b2b_count got %0d want 3", n);
      end else begin
         checks++;
         if ((acc[1] - acc[0]) != GAP || (acc[2] - acc[1]) != GAP) begin
            errors++;
            $display("FAIL b2b_spacing got %0d,%0d want %0d", acc[1] - acc[0], acc[2] - acc[1], GAP);
         end
      end
      repeat (8) @(negedge clk);
   endtask

   task automatic test_random();
      int unsigned acc;
      for (int k = 0; k < 24; k++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         send(16'($urandom), acc);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL random_drain got %0d pending want 0", exp_q.size());
      end
   endtask

   task automatic test_wrap();
      int unsigned acc;
      @(posedge clk); #1;
      force tb_exec_ctrl.dut.r_retired_cnt = 16'hFFFF;
      preload = 1'b1;
      @(posedge clk); #1;
      release tb_exec_ctrl.dut.r_retired_cnt;
      preload = 1'b0;
      send(16'h2111, acc);
      wait_done();
      checks++;
      if (retired_cnt !== 16'h0000) begin
         errors++;
         $display("FAIL wrap got %h want 0000", retired_cnt);
      end
   endtask

   task automatic test_params();
      int wk;
      int dk;
      wk = 0;
      dk = 0;
      @(posedge clk); #1;
      instr2 = 16'h1567;
      instr2_valid = 1'b1;
      rf2_adat = 16'd0;
      @(negedge clk);
      checks++;
      if (instr2_ready !== 1'b1) begin
         errors++;
         $display("FAIL params_ready got %0b want 1", instr2_ready);
      end
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         instr2_valid = 1'b0;
         rf2_adat = 16'(k);
         @(negedge clk);
         if (rf2_wren && wk == 0) wk = k;
         if (done2 && dk == 0) dk = k;
      end
      checks++;
      if (wk != 5 || dk != 5) begin
         errors++;
         $display("FAIL params_latency got wren@%0d done@%0d want 5 5", wk, dk);
      end
      checks++;
      if (alu2_a !== 16'd3 || alu2_b !== 16'h00AA || alu2_op !== 4'd1) begin
         errors++;
         $display("FAIL params_operands got a=%h b=%h op=%0h want 0003 00aa 1", alu2_a, alu2_b, alu2_op);
      end
      checks++;
      if (rf2_rw !== 4'd5 || rf2_wdat !== 16'h00AD || rf2_ra !== 4'd6 || rf2_rb !== 4'd7 || retired2_cnt !== 16'd1) begin
         errors++;
         $display("FAIL params_write got rw=%0h wdat=%h ra=%0h rb=%0h ret=%h want 5 00ad 6 7 0001",
                  rf2_rw, rf2_wdat, rf2_ra, rf2_rb, retired2_cnt);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_nop();
      test_back_to_back();
      test_random();
      test_wrap();
      test_params();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
